// File: rtl/sw_debouncer.sv
// Slide-switch conditioner: two-flop synchroniser followed by a word-wide
// stable-time debouncer that commits the whole word at once with a change strobe.
module sw_debouncer #(
    parameter int N_SW    = 8,
    parameter int CNT_MAX = 500000,
    parameter int CNT_W   = 20
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_SW-1:0] sw_i,
    output logic [N_SW-1:0] sw_o,
    output logic            sw_chg_o,
    output logic            busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_SW-1:0]  sync1_r;
    logic [N_SW-1:0]  sync2_r;
    logic [N_SW-1:0]  sw_s;
    logic [N_SW-1:0]  cand_r;
    logic [N_SW-1:0]  cand_s;
    logic [N_SW-1:0]  sw_r;
    logic [N_SW-1:0]  sw_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             chg_r;
    logic             chg_s;
    logic             busy_r;
    state_t           state_r;
    state_t           state_s;

    // Two-flop synchroniser; the only logic that samples the raw switches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_r <= {N_SW{1'b0}};
            sync2_r <= {N_SW{1'b0}};
        end else begin
            sync1_r <= sw_i;
            sync2_r <= sync1_r;
        end
    end

    assign sw_s = sync2_r;

    // State, candidate, counter and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cand_r  <= {N_SW{1'b0}};
            cnt_r   <= CNT_ZERO;
            sw_r    <= {N_SW{1'b0}};
            chg_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cand_r  <= cand_s;
            cnt_r   <= cnt_s;
            sw_r    <= sw_nxt_s;
            chg_r   <= chg_s;
            busy_r  <= (state_s == WAIT);
        end
    end

    // Next-state logic; any departure from the candidate restarts the full window.
    always_comb begin
        state_s  = state_r;
        cand_s   = cand_r;
        cnt_s    = cnt_r;
        sw_nxt_s = sw_r;
        chg_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (sw_s != sw_r) begin
                    state_s = WAIT;
                    cand_s  = sw_s;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (sw_s == sw_r) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (sw_s != cand_r) begin
                    cand_s = sw_s;
                    cnt_s  = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    sw_nxt_s = cand_r;
                    chg_s    = 1'b1;
                    cnt_s    = CNT_ZERO;
                    state_s  = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    assign sw_o     = sw_r;
    assign sw_chg_o = chg_r;
    assign busy_o   = busy_r;

endmodule

// File: tb/tb_sw_debouncer.sv
// Scoreboard bench for sw_debouncer (N_SW=8, CNT_MAX=4): expected commits are
// queued with their due edge when stimulus is applied and checked on each strobe.
module tb_sw_debouncer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] sw_i  = 8'h00;
    logic [7:0] sw_o;
    logic       sw_chg_o;
    logic       busy_o;

    typedef struct {
        int         edge_no;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    sw_debouncer #(.N_SW(8), .CNT_MAX(4), .CNT_W(3)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sw_i     (sw_i),
        .sw_o     (sw_o),
        .sw_chg_o (sw_chg_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    // A value applied now is captured at edge cyc+1 and commits CNT_MAX+2 edges later.
    task automatic expect_commit(input logic [7:0] v);
        exp_t e;
        e.edge_no = cyc + 7;
        e.val     = v;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic [7:0] v);
        sw_i  = v;
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sw_chg_o !== 1'b0) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL strobe_unexpected edge=%0d sw_o=%h required no strobe", cyc, sw_o);
                end else begin
                    e = sb.pop_front();
                    if (e.edge_no != cyc || sw_o !== e.val) begin
                        miscompares++;
                        $display("FAIL strobe_commit got edge=%0d sw_o=%h required edge=%0d sw_o=%h",
                                 cyc, sw_o, e.edge_no, e.val);
                    end
                end
            end else if (sb.size() > 0 && sb[0].edge_no <= cyc) begin
                e = sb.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL strobe_missing edge=%0d sw_o=%h required strobe with %h", cyc, sw_o, e.val);
            end
        end
    endtask

    task automatic test_reset();
        int rel;
        int off;
        rst_i = 1'b1;
        sw_i  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (sw_o !== 8'h00 || sw_chg_o !== 1'b0 || busy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold sw_o=%h chg=%b busy=%b required 00/0/0", sw_o, sw_chg_o, busy_o);
            end
        end
        rst_i = 1'b0;
        rel   = cyc;
        expect_commit(8'hA5);
        for (int i = 0; i < 8; i++) begin
            step();
            off = cyc - (rel + 1);
            vectors++;
            if (busy_o !== ((off >= 2 && off <= 5) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL reset_busy e0+%0d busy=%b required %b", off, busy_o,
                         (off >= 2 && off <= 5) ? 1'b1 : 1'b0);
            end
            vectors++;
            if (sw_o !== ((off >= 6) ? 8'hA5 : 8'h00)) begin
                miscompares++;
                $display("FAIL reset_sw e0+%0d sw_o=%h required %h", off, sw_o, (off >= 6) ? 8'hA5 : 8'h00);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset(8'h00);
        step();
        sw_i = 8'h01;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_busy_rise busy=%b required 1", busy_o);
        end
        sw_i = 8'h00;
        for (int i = 0; i < 6; i++) step();
        vectors++;
        if (busy_o !== 1'b0 || sw_o !== 8'h00) begin
            miscompares++;
            $display("FAIL glitch_reject busy=%b sw_o=%h required 0/00", busy_o, sw_o);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat [6];
        pat = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
        for (int i = 0; i < 6; i++) begin
            sw_i = pat[i];
            if (i == 5) expect_commit(8'h01);
            step();
        end
        for (int i = 0; i < 10; i++) step();
        vectors++;
        if (sw_o !== 8'h01 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL bounce_final sw_o=%h pending=%0d required 01/0", sw_o, sb.size());
        end
    endtask

    task automatic test_multibit();
        do_reset(8'h00);
        step();
        sw_i = 8'h01;
        step();
        step();
        sw_i = 8'h03;
        expect_commit(8'h03);
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (sw_o === 8'h01) begin
                miscompares++;
                $display("FAIL multibit_intermediate sw_o=%h required not 01", sw_o);
            end
        end
        vectors++;
        if (sw_o !== 8'h03 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL multibit_final sw_o=%h pending=%0d required 03/0", sw_o, sb.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset(8'h00);
        sw_i = 8'h11;
        expect_commit(8'h11);
        for (int i = 0; i < 8; i++) step();
        vectors++;
        if (sw_o !== 8'h11) begin
            miscompares++;
            $display("FAIL async_pre sw_o=%h required 11", sw_o);
        end
        sw_i = 8'h3C;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL async_busy busy=%b required 1", busy_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        vectors++;
        if (sw_o !== 8'h00 || busy_o !== 1'b0 || sw_chg_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_clear sw_o=%h busy=%b chg=%b required 00/0/0", sw_o, busy_o, sw_chg_o);
        end
        step();
        step();
        rst_i = 1'b0;
        expect_commit(8'h3C);
        for (int i = 0; i < 8; i++) step();
        vectors++;
        if (sw_o !== 8'h3C || sb.size() != 0) begin
            miscompares++;
            $display("FAIL async_recommit sw_o=%h pending=%0d required 3C/0", sw_o, sb.size());
        end
    endtask

    // Both alternating words differ from the committed 3C, so every change restarts timing.
    task automatic test_back_to_back();
        int k;
        k = cyc;
        for (int i = 0; i < 50; i++) begin
            sw_i = (((i / 3) % 2) == 0) ? 8'hFF : 8'h00;
            step();
            if (cyc >= k + 3) begin
                vectors++;
                if (busy_o !== 1'b1 || sw_o !== 8'h3C) begin
                    miscompares++;
                    $display("FAIL b2b_hold edge=%0d busy=%b sw_o=%h required 1/3C", cyc, busy_o, sw_o);
                end
            end
        end
        sw_i = 8'h3C;
        for (int i = 0; i < 6; i++) step();
        vectors++;
        if (busy_o !== 1'b0 || sw_o !== 8'h3C || sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_settle busy=%b sw_o=%h pending=%0d required 0/3C/0", busy_o, sw_o, sb.size());
        end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_glitch();
        test_bounce();
        test_multibit();
        test_async_reset();
        test_back_to_back();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
